// File: rtl/fetch_pkg.sv
// fetch_pkg: opcodes, NOP encoding and fetch FSM state encoding shared by the fetch stage.
package fetch_pkg;
    localparam logic [4:0]  OP_HALT  = 5'b00000;
    localparam logic [15:0] NOP_INST = 16'h0800;
    typedef enum logic [1:0] {FETCH, WAIT, HALTED} state_t;
    function automatic logic is_halt(input logic [15:0] inst);
        return inst[15:11] == OP_HALT;
    endfunction
endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline register with flush, load, hold-on-stall and drain.
module ifid_reg import fetch_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        load,
    input  logic        stall,
    input  logic [15:0] load_pc,
    input  logic [15:0] load_inst,
    output logic        valid,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic [15:0] instruction
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid       <= 1'b0;
            pc          <= '0;
            pc_plus2    <= '0;
            instruction <= NOP_INST;
        end else if (flush) begin
            valid       <= 1'b0;
            instruction <= NOP_INST;
        end else if (load) begin
            valid       <= 1'b1;
            pc          <= load_pc;
            pc_plus2    <= load_pc + 16'd2;
            instruction <= load_inst;
        end else if (!stall) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch FSM feeding the IF/ID register.
// Optional statistics counters are built when FETCH_STATS_EN is defined.
module fetch_stage import fetch_pkg::*; #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        if_valid,
    output logic [15:0] pc,
    output logic [15:0] instruction,
    output logic [15:0] pc_plus2,
    output logic        halted,
    output logic [15:0] fetch_count,
    output logic [15:0] stall_count
);
    state_t      state, state_nx;
    logic [15:0] fetch_pc, fetch_pc_nx;
    logic        done;

    // a redirect abandons whatever is in flight, so the request drops in that same cycle
    assign imem_req  = rst && !redirect && state != HALTED;
    assign imem_addr = fetch_pc;
    assign done      = imem_req && imem_valid && (!if_valid || !stall);
    assign halted    = state == HALTED;

    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        if (redirect) begin
            state_nx    = FETCH;
            fetch_pc_nx = redirect_pc;
        end else if (done) begin
            state_nx    = is_halt(imem_rdata) ? HALTED : FETCH;
            fetch_pc_nx = fetch_pc + 16'd2;
        end else if (imem_req) begin
            state_nx = WAIT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_nx;
            fetch_pc <= fetch_pc_nx;
        end
    end

    ifid_reg u_ifid (
        .clk         (clk),
        .rst         (rst),
        .flush       (redirect),
        .load        (done),
        .stall       (stall),
        .load_pc     (fetch_pc),
        .load_inst   (imem_rdata),
        .valid       (if_valid),
        .pc          (pc),
        .pc_plus2    (pc_plus2),
        .instruction (instruction)
    );

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (done && fetch_count != 16'hFFFF)
                fetch_count <= fetch_count + 16'd1;
            if (if_valid && stall && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
        end
    end
`else
    assign fetch_count = '0;
    assign stall_count = '0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        if_valid;
    logic [15:0] pc, instruction, pc_plus2, fetch_count, stall_count;
    logic        halted;
    int n = 0;
    int errs = 0;

    fetch_stage #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .if_valid(if_valid),
        .pc(pc), .instruction(instruction), .pc_plus2(pc_plus2), .halted(halted),
        .fetch_count(fetch_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; imem_valid = 1'b0; imem_rdata = '0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        #1;
    endtask

    task automatic cyc(input logic v, input logic [15:0] d, input logic s, input logic r, input logic [15:0] rp);
        @(negedge clk);
        rst = 1'b1; imem_valid = v; imem_rdata = d; stall = s; redirect = r; redirect_pc = rp;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n++; if (imem_req !== 1'b0) begin errs++; $display("FAIL rst_req: got %b exp 0", imem_req); end
        n++; if (if_valid !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b exp 0", if_valid); end
        n++; if (pc !== 16'h0000) begin errs++; $display("FAIL rst_pc: got %h exp 0000", pc); end
        n++; if (pc_plus2 !== 16'h0000) begin errs++; $display("FAIL rst_pc2: got %h exp 0000", pc_plus2); end
        n++; if (instruction !== 16'h0800) begin errs++; $display("FAIL rst_inst: got %h exp 0800", instruction); end
        n++; if (halted !== 1'b0) begin errs++; $display("FAIL rst_halted: got %b exp 0", halted); end
        n++; if (fetch_count !== 16'h0 || stall_count !== 16'h0) begin errs++; $display("FAIL rst_counts: got %h/%h exp 0/0", fetch_count, stall_count); end
    endtask

    task automatic test_zero_wait_and_stall();
        cyc(1, 16'h1111, 0, 0, 0);
        n++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errs++; $display("FAIL zw_c1: got req %b addr %h exp 1 0000", imem_req, imem_addr); end
        n++; if (if_valid !== 1'b0) begin errs++; $display("FAIL zw_c1_valid: got %b exp 0", if_valid); end
        cyc(1, 16'h2222, 0, 0, 0);
        n++; if (imem_addr !== 16'h0002 || if_valid !== 1'b1) begin errs++; $display("FAIL zw_c2: got addr %h valid %b exp 0002 1", imem_addr, if_valid); end
        n++; if (pc !== 16'h0000 || pc_plus2 !== 16'h0002 || instruction !== 16'h1111) begin errs++; $display("FAIL zw_c2_ifid: got %h %h %h exp 0000 0002 1111", pc, pc_plus2, instruction); end
        cyc(1, 16'h4123, 0, 0, 0);
        n++; if (imem_addr !== 16'h0004 || pc !== 16'h0002 || pc_plus2 !== 16'h0004 || instruction !== 16'h2222) begin errs++; $display("FAIL zw_c3: got %h %h %h %h exp 0004 0002 0004 2222", imem_addr, pc, pc_plus2, instruction); end
        for (int i = 0; i < 4; i++) begin
            cyc(1, 16'h5555, 1, 0, 0);
            n++; if (if_valid !== 1'b1 || pc !== 16'h0004 || pc_plus2 !== 16'h0006 || instruction !== 16'h4123) begin errs++; $display("FAIL stall_hold%0d: got %b %h %h %h exp 1 0004 0006 4123", i, if_valid, pc, pc_plus2, instruction); end
            n++; if (imem_addr !== 16'h0006 || imem_req !== 1'b1) begin errs++; $display("FAIL stall_addr%0d: got %h %b exp 0006 1", i, imem_addr, imem_req); end
        end
        cyc(0, 16'h0000, 0, 0, 0);
        n++; if (pc !== 16'h0004 || instruction !== 16'h4123) begin errs++; $display("FAIL stall_after: got %h %h exp 0004 4123", pc, instruction); end
`ifdef FETCH_STATS_EN
        n++; if (stall_count !== 16'd4 || fetch_count !== 16'd3) begin errs++; $display("FAIL stall_counts: got %0d/%0d exp 4/3", stall_count, fetch_count); end
`else
        n++; if (stall_count !== 16'd0 || fetch_count !== 16'd0) begin errs++; $display("FAIL stall_counts: got %0d/%0d exp 0/0", stall_count, fetch_count); end
`endif
        cyc(0, 16'h0000, 0, 0, 0);
        n++; if (if_valid !== 1'b0 || pc !== 16'h0004) begin errs++; $display("FAIL drain: got %b %h exp 0 0004", if_valid, pc); end
    endtask

    task automatic test_delay_and_redirect();
        do_reset();
        cyc(1, 16'h1111, 0, 0, 0);
        cyc(0, 16'h0000, 0, 0, 0);
        n++; if (imem_req !== 1'b1 || imem_addr !== 16'h0002 || if_valid !== 1'b1) begin errs++; $display("FAIL dly_c2: got %b %h %b exp 1 0002 1", imem_req, imem_addr, if_valid); end
        cyc(0, 16'h0000, 0, 0, 0);
        n++; if (imem_req !== 1'b1 || imem_addr !== 16'h0002 || if_valid !== 1'b0) begin errs++; $display("FAIL dly_c3: got %b %h %b exp 1 0002 0", imem_req, imem_addr, if_valid); end
        cyc(0, 16'h0000, 0, 0, 0);
        n++; if (imem_req !== 1'b1 || imem_addr !== 16'h0002) begin errs++; $display("FAIL dly_c4: got %b %h exp 1 0002", imem_req, imem_addr); end
        cyc(1, 16'hABCD, 0, 0, 0);
        n++; if (imem_addr !== 16'h0002 || pc !== 16'h0000) begin errs++; $display("FAIL dly_c5: got %h %h exp 0002 0000", imem_addr, pc); end
        cyc(0, 16'h0000, 0, 0, 0);
        n++; if (if_valid !== 1'b1 || pc !== 16'h0002 || instruction !== 16'hABCD || imem_addr !== 16'h0004) begin errs++; $display("FAIL dly_load: got %b %h %h %h exp 1 0002 abcd 0004", if_valid, pc, instruction, imem_addr); end
        cyc(0, 16'h0000, 0, 0, 0);
        n++; if (if_valid !== 1'b0 || pc !== 16'h0002 || instruction !== 16'hABCD) begin errs++; $display("FAIL dly_once: got %b %h %h exp 0 0002 abcd", if_valid, pc, instruction); end
        cyc(1, 16'hDEAD, 0, 1, 16'h0040);
        n++; if (imem_req !== 1'b0) begin errs++; $display("FAIL redir_req: got %b exp 0", imem_req); end
        cyc(1, 16'h7777, 0, 0, 0);
        n++; if (if_valid !== 1'b0 || instruction !== 16'h0800 || imem_addr !== 16'h0040 || imem_req !== 1'b1) begin errs++; $display("FAIL redir_next: got %b %h %h %b exp 0 0800 0040 1", if_valid, instruction, imem_addr, imem_req); end
        cyc(1, 16'h8888, 1, 1, 16'h0100);
        n++; if (if_valid !== 1'b1 || pc !== 16'h0040 || instruction !== 16'h7777 || imem_req !== 1'b0) begin errs++; $display("FAIL redir_stall_c: got %b %h %h %b exp 1 0040 7777 0", if_valid, pc, instruction, imem_req); end
        cyc(0, 16'h0000, 0, 0, 0);
        n++; if (if_valid !== 1'b0 || instruction !== 16'h0800 || imem_addr !== 16'h0100) begin errs++; $display("FAIL redir_stall: got %b %h %h exp 0 0800 0100", if_valid, instruction, imem_addr); end
`ifdef FETCH_STATS_EN
        n++; if (fetch_count !== 16'd3) begin errs++; $display("FAIL redir_fcount: got %0d exp 3", fetch_count); end
`endif
    endtask

    task automatic test_halt();
        do_reset();
        cyc(1, 16'h1111, 0, 0, 0);
        cyc(1, 16'h2222, 0, 0, 0);
        cyc(1, 16'h3333, 0, 0, 0);
        cyc(1, 16'h0000, 0, 0, 0);
        n++; if (imem_addr !== 16'h0006 || halted !== 1'b0) begin errs++; $display("FAIL halt_pre: got %h %b exp 0006 0", imem_addr, halted); end
        cyc(1, 16'h9999, 0, 0, 0);
        n++; if (halted !== 1'b1 || imem_req !== 1'b0) begin errs++; $display("FAIL halt_state: got %b %b exp 1 0", halted, imem_req); end
        n++; if (if_valid !== 1'b1 || pc !== 16'h0006 || instruction !== 16'h0000) begin errs++; $display("FAIL halt_ifid: got %b %h %h exp 1 0006 0000", if_valid, pc, instruction); end
        cyc(0, 16'h0000, 0, 0, 0);
        n++; if (halted !== 1'b1 || imem_req !== 1'b0 || if_valid !== 1'b0) begin errs++; $display("FAIL halt_stay: got %b %b %b exp 1 0 0", halted, imem_req, if_valid); end
        cyc(0, 16'h0000, 0, 1, 16'h0010);
        n++; if (imem_req !== 1'b0) begin errs++; $display("FAIL halt_redir_req: got %b exp 0", imem_req); end
        cyc(1, 16'h1234, 0, 0, 0);
        n++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0010) begin errs++; $display("FAIL halt_resume: got %b %b %h exp 0 1 0010", halted, imem_req, imem_addr); end
        cyc(0, 16'h0000, 0, 0, 0);
        n++; if (if_valid !== 1'b1 || pc !== 16'h0010 || instruction !== 16'h1234) begin errs++; $display("FAIL halt_refetch: got %b %h %h exp 1 0010 1234", if_valid, pc, instruction); end
    endtask

    task automatic test_wrap();
        do_reset();
        cyc(0, 16'h0000, 0, 1, 16'hFFFE);
        cyc(1, 16'h9999, 0, 0, 0);
        n++; if (imem_req !== 1'b1 || imem_addr !== 16'hFFFE) begin errs++; $display("FAIL wrap_addr: got %b %h exp 1 fffe", imem_req, imem_addr); end
        cyc(0, 16'h0000, 0, 0, 0);
        n++; if (pc !== 16'hFFFE || pc_plus2 !== 16'h0000 || instruction !== 16'h9999) begin errs++; $display("FAIL wrap_ifid: got %h %h %h exp fffe 0000 9999", pc, pc_plus2, instruction); end
        n++; if (imem_addr !== 16'h0000) begin errs++; $display("FAIL wrap_next: got %h exp 0000", imem_addr); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        cyc(1, 16'h1111, 0, 0, 0);
        cyc(0, 16'h0000, 0, 0, 0);
        n++; if (if_valid !== 1'b1 || imem_addr !== 16'h0002) begin errs++; $display("FAIL mid_pre: got %b %h exp 1 0002", if_valid, imem_addr); end
        do_reset();
        imem_valid = 1'b1; imem_rdata = 16'h5A5A;
        #1;
        n++; if (if_valid !== 1'b0 || instruction !== 16'h0800 || pc !== 16'h0000 || imem_req !== 1'b0) begin errs++; $display("FAIL mid_rst: got %b %h %h %b exp 0 0800 0000 0", if_valid, instruction, pc, imem_req); end
        cyc(0, 16'h0000, 0, 0, 0);
        n++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || if_valid !== 1'b0 || instruction !== 16'h0800) begin errs++; $display("FAIL mid_release: got %b %h %b %h exp 1 0000 0 0800", imem_req, imem_addr, if_valid, instruction); end
    endtask

    initial begin
        test_reset();
        test_zero_wait_and_stall();
        test_delay_and_redirect();
        test_halt();
        test_wrap();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n, errs);
        $finish;
    end
endmodule
